// File: rtl/deser_arbiter_pkg.sv
// Shared types and width helpers for the deserializer arbiter.
// Optional stall timeout is enabled with DESER_ARB_TIMEOUT_EN.
package deser_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // Counter/index width for n values, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/deser_arbiter_rr_select.sv
// Combinational round-robin pick: first asserted request at or after ptr.
// Used by deser_arbiter; no configuration macros.
module rr_select
   import deser_arbiter_pkg::*;
#(
   parameter int N = 4,
   parameter int W = width_of(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         any,
   output logic [W-1:0] idx
);

   int j;

   // Scan farthest-first so the nearest requester overwrites the result.
   always_comb begin
      any = 1'b0;
      idx = '0;
      j   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            any = 1'b1;
            idx = W'(j);
         end
      end
   end

endmodule

// File: rtl/deser_arbiter.sv
// Frame-locked round-robin arbiter feeding one serial-to-parallel datapath.
// Define DESER_ARB_TIMEOUT_EN to add the TIMEOUT parameter and abort output.
module deser_arbiter
   import deser_arbiter_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int NWORDS   = 8,
   parameter int BITWIDTH = 16
`ifdef DESER_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT  = 16
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_val,
   input  logic [NREQ*BITWIDTH-1:0] req_msg,
   output logic [NREQ-1:0]          req_rdy,
   output logic                     out_val,
   output logic [BITWIDTH-1:0]      out_msg,
   input  logic                     out_rdy,
   output logic [width_of(NREQ)-1:0] out_src,
   output logic                     out_last,
   output logic                     busy
`ifdef DESER_ARB_TIMEOUT_EN
   ,
   output logic                     abort
`endif
);

   localparam int SW = width_of(NREQ);
   localparam int CW = width_of(NWORDS);

   state_t        state, state_n;
   logic [SW-1:0] gnt, gnt_n;
   logic [SW-1:0] ptr, ptr_n;
   logic [SW-1:0] ptr_adv;
   logic [SW-1:0] sel_idx;
   logic [CW-1:0] cnt, cnt_n;
   logic          sel_any;
   logic          in_burst;
   logic          hs;
   logic          last;
   logic          expire;

   rr_select #(
      .N (NREQ),
      .W (SW)
   ) u_sel (
      .req (req_val),
      .ptr (ptr),
      .any (sel_any),
      .idx (sel_idx)
   );

   assign in_burst = (state == BURST);
   assign out_val  = in_burst & req_val[gnt];
   assign out_msg  = in_burst ? req_msg[gnt*BITWIDTH +: BITWIDTH] : '0;
   assign out_src  = in_burst ? gnt : '0;
   assign last     = in_burst && (cnt == CW'(NWORDS - 1));
   assign out_last = last;
   assign busy     = in_burst;
   assign hs       = out_val & out_rdy;
   assign ptr_adv  = (gnt == SW'(NREQ - 1)) ? '0 : gnt + 1'b1;

   always_comb begin
      req_rdy = '0;
      if (in_burst) req_rdy[gnt] = out_rdy;
   end

`ifdef DESER_ARB_TIMEOUT_EN
   localparam int TW = width_of(TIMEOUT + 1);

   logic [TW-1:0] stall;

   // Fires on the cycle that would bring the stall count to TIMEOUT.
   assign expire = in_burst && !hs && (stall == TW'(TIMEOUT - 1));
   assign abort  = expire;

   always_ff @(posedge clk) begin
      if (reset)
         stall <= '0;
      else if (!in_burst || hs)
         stall <= '0;
      else
         stall <= stall + 1'b1;
   end
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      ptr_n   = ptr;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (sel_any) begin
               state_n = BURST;
               gnt_n   = sel_idx;
               cnt_n   = '0;
            end
         end
         BURST: begin
            if ((hs && last) || expire) begin
               state_n = IDLE;
               ptr_n   = ptr_adv;
               cnt_n   = '0;
            end else if (hs) begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_deser_arbiter.sv
// Self-checking bench for deser_arbiter: vector table, directed sequences,
// and random traffic against a frame-level reference model.
module tb_deser_arbiter;
   import deser_arbiter_pkg::*;

   localparam int NREQ    = 4;
   localparam int NWORDS  = 8;
   localparam int BW      = 16;
   localparam int TIMEOUT = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_val;
   logic [NREQ*BW-1:0]   req_msg;
   logic [NREQ-1:0]      req_rdy;
   logic                 out_val;
   logic [BW-1:0]        out_msg;
   logic                 out_rdy;
   logic [1:0]           out_src;
   logic                 out_last;
   logic                 busy;
`ifdef DESER_ARB_TIMEOUT_EN
   logic                 abort;
`endif

   always #5 clk = ~clk;

   deser_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .req_val  (req_val),
      .req_msg  (req_msg),
      .req_rdy  (req_rdy),
      .out_val  (out_val),
      .out_msg  (out_msg),
      .out_rdy  (out_rdy),
      .out_src  (out_src),
      .out_last (out_last),
      .busy     (busy)
`ifdef DESER_ARB_TIMEOUT_EN
      ,
      .abort    (abort)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Reference model: a frame owner, words done in the frame, next-start ptr.
   bit m_valid = 1'b0;
   bit m_busy;
   int m_g, m_words, m_ptr, m_stall;

   logic            s_busy, s_val, s_last, s_abort;
   logic [1:0]      s_src;
   logic [3:0]      s_rrdy;
   logic [BW-1:0]   s_msg;

   typedef struct {
      logic       rst;
      logic [3:0] rv;
      logic       rdy;
      logic       busy;
      logic       val;
      logic       last;
      logic [1:0] src;
      logic [3:0] rrdy;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [24:0] model_out(input logic [3:0] rv,
                                             input logic rdy,
                                             input logic [63:0] msg);
      logic [3:0] rr;
      if (!m_busy) return '0;
      rr = '0;
      rr[m_g] = rdy;
      return {1'b1, rv[m_g], m_words == NWORDS - 1, 2'(m_g), rr,
              msg[m_g*BW +: BW]};
   endfunction

   task automatic model_step(input logic rst, input logic [3:0] rv,
                             input logic rdy);
      bit found;
      bit hs;
      if (rst) begin
         m_busy = 0; m_g = 0; m_words = 0; m_ptr = 0; m_stall = 0;
         m_valid = 1;
         return;
      end
      if (!m_valid) return;
      if (!m_busy) begin
         found = 0;
         for (int k = 0; k < NREQ; k++) begin
            if (!found && rv[(m_ptr + k) % NREQ]) begin
               m_g = (m_ptr + k) % NREQ;
               found = 1;
            end
         end
         if (found) begin
            m_busy = 1; m_words = 0; m_stall = 0;
         end
      end else begin
         hs = rv[m_g] && rdy;
         if (hs) begin
            m_stall = 0;
            if (m_words == NWORDS - 1) begin
               m_busy = 0;
               m_ptr = (m_g + 1) % NREQ;
            end else begin
               m_words++;
            end
         end else begin
`ifdef DESER_ARB_TIMEOUT_EN
            if (m_stall == TIMEOUT - 1) begin
               m_busy = 0;
               m_ptr = (m_g + 1) % NREQ;
            end else begin
               m_stall++;
            end
`endif
         end
      end
   endtask

   task automatic cycle(input logic rst, input logic [3:0] rv,
                        input logic rdy);
      logic [63:0] msg;
      @(negedge clk);
      msg     = {$urandom, $urandom};
      reset   = rst;
      req_val = rv;
      out_rdy = rdy;
      req_msg = msg;
      #1;
      s_busy = busy; s_val = out_val; s_last = out_last;
      s_src = out_src; s_rrdy = req_rdy; s_msg = out_msg;
      s_abort = 1'b0;
      if (m_valid)
         check("model_outputs", 32'({busy, out_val, out_last, out_src,
               req_rdy, out_msg}), 32'(model_out(rv, rdy, msg)));
`ifdef DESER_ARB_TIMEOUT_EN
      s_abort = abort;
      if (m_valid)
         check("model_abort", 32'(abort), 32'(m_busy && !(rv[m_g] && rdy)
               && m_stall == TIMEOUT - 1));
`endif
      @(posedge clk);
      model_step(rst, rv, rdy);
   endtask

   task automatic add(input logic rst, input logic [3:0] rv, input logic rdy,
                      input logic b, input logic v, input logic l,
                      input logic [1:0] src, input logic [3:0] rr);
      vec_t r;
      r.rst = rst; r.rv = rv; r.rdy = rdy; r.busy = b; r.val = v;
      r.last = l; r.src = src; r.rrdy = rr;
      tbl.push_back(r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hs, held, frames, idle_run, phase;
      bit started, done, prev_busy, lock_bad;
      logic [3:0] other_rdy, rv;
      logic rdy;

      reset = 1; req_val = '0; req_msg = '0; out_rdy = 0;

      // Vector table: reset, single requester frame, pointer advance.
      add(1, 4'b0001, 1, 0, 0, 0, 0, 4'b0000);
      add(1, 4'b0001, 1, 0, 0, 0, 0, 4'b0000);
      add(0, 4'b0001, 1, 0, 0, 0, 0, 4'b0000);
      for (int w = 0; w < NWORDS; w++)
         add(0, 4'b0001, 1, 1, 1, w == NWORDS - 1, 0, 4'b0001);
      add(0, 4'b0011, 1, 0, 0, 0, 0, 4'b0000);
      add(0, 4'b0011, 1, 1, 1, 0, 1, 4'b0010);

      cycle(1, 4'b0000, 0);
      foreach (tbl[i]) begin
         cycle(tbl[i].rst, tbl[i].rv, tbl[i].rdy);
         check($sformatf("table_row%0d", i),
               32'({s_busy, s_val, s_last, s_src, s_rrdy, s_msg}),
               32'({tbl[i].busy, tbl[i].val, tbl[i].last, tbl[i].src,
                    tbl[i].rrdy, tbl[i].busy ?
                    req_msg[tbl[i].src*BW +: BW] : 16'h0}));
      end

      // All requesters continuous: order 0,1,2,3,0 with one idle gap.
      cycle(1, 0, 0); cycle(1, 0, 0);
      frames = 0; idle_run = 0; prev_busy = 0;
      for (int c = 0; c < 80 && frames < 5; c++) begin
         cycle(0, 4'b1111, 1);
         if (s_busy && !prev_busy) begin
            if (frames > 0) check("rr_gap", idle_run, 1);
            check("rr_order", 32'(s_src), frames % NREQ);
            frames++;
            idle_run = 0;
         end
         if (!s_busy) idle_run++;
         prev_busy = s_busy;
      end
      check("rr_frames", frames, 5);

      // Backpressure on requester 2 with a source stall at word 3.
      cycle(1, 0, 0);
      hs = 0; held = 0; started = 0; done = 0; other_rdy = '0;
      for (int c = 0; c < 100 && !done; c++) begin
         rdy = (c % 2 == 0);
         rv = 4'b0100;
         if (hs == 3 && held < 4) begin
            rv = 4'b0000;
            held++;
         end
         cycle(0, rv, rdy);
         other_rdy |= s_rrdy & 4'b1011;
         if (s_busy) started = 1;
         if (s_val && rdy) hs++;
         if (started && !s_busy) done = 1;
      end
      check("bp_done", 32'(done), 1);
      check("bp_words", hs, NWORDS);
      check("bp_other_rdy", 32'(other_rdy), 0);

      // Grant lock: requester 0 asserts mid-frame of requester 1.
      cycle(1, 0, 0);
      hs = 0; phase = 0; lock_bad = 0;
      for (int c = 0; c < 60 && phase < 3; c++) begin
         rv = (hs >= 4) ? 4'b0011 : 4'b0010;
         cycle(0, rv, 1);
         if (phase == 0 && s_busy) phase = 1;
         if (phase == 1) begin
            if (!s_busy) phase = 2;
            else if (s_src != 2'd1) lock_bad = 1;
            if (s_val) hs++;
         end else if (phase == 2 && s_busy) begin
            check("lock_next_src", 32'(s_src), 0);
            phase = 3;
         end
      end
      check("lock_held", 32'(lock_bad), 0);
      check("lock_words", hs, NWORDS);
      check("lock_phase", phase, 3);

      // Reset at word 5 abandons the frame; restart from word 0, pointer 0.
      cycle(1, 0, 0);
      hs = 0;
      for (int c = 0; c < 20 && hs < 5; c++) begin
         cycle(0, 4'b0001, 1);
         if (s_val) hs++;
      end
      cycle(1, 4'b0001, 1);
      check("rst_mid_busy", 32'(s_busy), 1);
      cycle(0, 4'b0011, 1);
      check("rst_outputs_zero",
            32'({s_busy, s_val, s_last, s_src, s_rrdy, s_msg}), 0);
      for (int w = 0; w < NWORDS; w++) begin
         cycle(0, 4'b0011, 1);
         if (w == 0) check("rst_restart_src", 32'(s_src), 0);
         check("rst_restart_last", 32'(s_last), 32'(w == NWORDS - 1));
      end

`ifdef DESER_ARB_TIMEOUT_EN
      // Granted requester goes silent after two words; frame is aborted.
      cycle(1, 0, 0);
      hs = 0; held = 0; done = 0; phase = 0;
      for (int c = 0; c < 60 && phase < 2; c++) begin
         rv = (hs >= 2) ? 4'b0010 : 4'b0011;
         cycle(0, rv, 1);
         if (phase == 0 && s_busy) begin
            if (s_val) hs++;
            else held++;
            if (s_abort) begin
               check("to_stall_cycles", held, TIMEOUT);
               phase = 1;
            end
         end else if (phase == 1 && s_busy) begin
            check("to_next_src", 32'(s_src), 1);
            phase = 2;
         end
      end
      check("to_phase", phase, 2);
`endif

      // Random traffic against the model.
      cycle(1, 0, 0);
      for (int c = 0; c < 400; c++)
         cycle(($urandom % 64) == 0, 4'($urandom), ($urandom % 4) != 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
